// File: rtl/comm_word_buffer_if.sv
// Byte-stream and word-port signals between comm_word_buffer and its PHY/interpreter.
// slave is the buffer's view; master is the surrounding environment's view.
interface comm_word_buffer_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic        read;
  logic        read_response;
  logic [31:0] read_data;
  logic        write;
  logic [31:0] write_data;
  logic        write_response;
  logic        rx_empty;
  logic        tx_empty;
  logic        rx_overflow;

  modport slave (
    input  rx_byte, rx_byte_valid, tx_byte_ready, read, write, write_data,
    output tx_byte, tx_byte_valid, read_response, read_data, write_response,
           rx_empty, tx_empty, rx_overflow
  );

  modport master (
    output rx_byte, rx_byte_valid, tx_byte_ready, read, write, write_data,
    input  tx_byte, tx_byte_valid, read_response, read_data, write_response,
           rx_empty, tx_empty, rx_overflow
  );
endinterface

// File: rtl/comm_word_buffer.sv
// Byte-to-word adapter: packs PHY bytes into an RX word FIFO and serializes
// interpreter words from a TX FIFO back out as a valid/ready byte stream.
module comm_word_buffer #(
  parameter int unsigned WORD_SIZE_BY      = 4,
  parameter int unsigned BUFFER_SIZE       = 8,
  parameter int unsigned RX_TIMEOUT_CYCLES = 0
) (
  input logic               clk,
  input logic               reset,
  comm_word_buffer_if.slave bus
);
  localparam int unsigned AW  = $clog2(BUFFER_SIZE);
  localparam int unsigned MSB = 8 * WORD_SIZE_BY - 1;
  localparam logic [31:0] WORD_MASK = (WORD_SIZE_BY >= 4) ? 32'hFFFF_FFFF
                                    : ((32'd1 << (8 * WORD_SIZE_BY)) - 32'd1);
  localparam logic [2:0]  LAST_BYTE = 3'(WORD_SIZE_BY - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} tx_state_t;

  // RX side
  logic [23:0] r_pack;
  logic [2:0]  r_byte_cnt;
  logic [31:0] r_idle_cnt;
  logic [31:0] r_rx_mem [BUFFER_SIZE];
  logic [AW:0] r_rx_wr, r_rx_rd;
  logic        r_read_response, r_rx_overflow;
  logic [31:0] r_read_data;

  logic [31:0] w_pack_next;
  logic        w_rx_word, w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;

  assign w_pack_next = {r_pack, bus.rx_byte};
  assign w_rx_word   = bus.rx_byte_valid && (r_byte_cnt == LAST_BYTE);
  assign w_rx_empty  = (r_rx_wr == r_rx_rd);
  assign w_rx_full   = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_rx_pop    = bus.read && !r_read_response && !w_rx_empty;
  // A same-cycle pop frees the slot, so a full FIFO can still take the word.
  assign w_rx_push   = w_rx_word && (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= w_pack_next & WORD_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack          <= '0;
      r_byte_cnt      <= '0;
      r_idle_cnt      <= '0;
      r_rx_wr         <= '0;
      r_rx_rd         <= '0;
      r_read_response <= 1'b0;
      r_read_data     <= '0;
      r_rx_overflow   <= 1'b0;
    end else begin
      r_read_response <= w_rx_pop;
      if (w_rx_pop) begin
        r_read_data <= r_rx_mem[r_rx_rd[AW-1:0]];
        r_rx_rd     <= r_rx_rd + (AW+1)'(1);
      end
      if (w_rx_push) r_rx_wr <= r_rx_wr + (AW+1)'(1);
      if (w_rx_word && !w_rx_push) r_rx_overflow <= 1'b1;

      if (bus.rx_byte_valid) begin
        r_pack     <= w_pack_next[23:0];
        r_byte_cnt <= w_rx_word ? 3'd0 : r_byte_cnt + 3'd1;
        r_idle_cnt <= '0;
      end else if (RX_TIMEOUT_CYCLES != 0 && r_byte_cnt != 3'd0) begin
        if (r_idle_cnt == 32'(RX_TIMEOUT_CYCLES - 1)) begin
          r_pack     <= '0;
          r_byte_cnt <= '0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 32'd1;
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  // TX side
  logic [31:0] r_tx_mem [BUFFER_SIZE];
  logic [AW:0] r_tx_wr, r_tx_rd;
  logic        r_write_response, r_tx_byte_valid;
  logic [31:0] r_shift;
  logic [2:0]  r_left;
  tx_state_t   r_state;

  logic        w_tx_fifo_empty, w_tx_full, w_tx_push, w_tx_hs;
  logic [31:0] w_tx_head;

  assign w_tx_fifo_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full       = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_tx_push       = bus.write && !r_write_response && !w_tx_full;
  assign w_tx_hs         = r_tx_byte_valid && bus.tx_byte_ready;
  assign w_tx_head       = r_tx_mem[r_tx_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= bus.write_data & WORD_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr          <= '0;
      r_tx_rd          <= '0;
      r_write_response <= 1'b0;
      r_tx_byte_valid  <= 1'b0;
      r_shift          <= '0;
      r_left           <= '0;
      r_state          <= S_IDLE;
    end else begin
      r_write_response <= w_tx_push;
      if (w_tx_push) r_tx_wr <= r_tx_wr + (AW+1)'(1);
      case (r_state)
        S_IDLE: begin
          if (!w_tx_fifo_empty) begin
            r_shift         <= w_tx_head;
            r_left          <= 3'(WORD_SIZE_BY);
            r_tx_byte_valid <= 1'b1;
            r_tx_rd         <= r_tx_rd + (AW+1)'(1);
            r_state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_tx_hs) begin
            r_shift <= r_shift << 8;
            r_left  <= r_left - 3'd1;
            if (r_left == 3'd1) begin
              r_tx_byte_valid <= 1'b0;
              r_state         <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // tx_byte is a plain slice of the shift register, so it is registered and holds under back-pressure.
  assign bus.tx_byte        = r_shift[MSB -: 8];
  assign bus.tx_byte_valid  = r_tx_byte_valid;
  assign bus.read_response  = r_read_response;
  assign bus.read_data      = r_read_data;
  assign bus.write_response = r_write_response;
  assign bus.rx_empty       = w_rx_empty;
  assign bus.tx_empty       = w_tx_fifo_empty && (r_state == S_IDLE);
  assign bus.rx_overflow    = r_rx_overflow;
endmodule
